// File: rtl/mem_rsp_sram.sv
// mem_rsp_sram: local data SRAM responder for the req/gnt/rvalid data-memory protocol.
// Accepts one load or store at a time and returns exactly one rvalid pulse per accepted
// request, LATENCY cycles after the accept edge. Stores commit on the accept edge with
// per-byte enables. Out-of-range addresses return err with no array access.
//
// Ports:
//   clk       clock
//   rst       asynchronous reset, active-high (array contents are not reset)
//   req_i     request valid, held until granted
//   we_i      1 = store, 0 = load
//   addr_i    byte address (bits [1:0] ignored)
//   be_i      store byte lane enables
//   wdata_i   lane-aligned store data
//   gnt_o     combinational grant
//   rvalid_o  one-cycle response pulse
//   rdata_o   load data, qualified by rvalid_o
//   err_o     out-of-range flag, qualified by rvalid_o
module mem_rsp_sram #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // 33-bit end address so a window reaching the top of the address space cannot wrap.
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
    // BUSY spends LATENCY-1 edges; the counter terminal value is LATENCY-2.
    localparam logic [1:0]  LAST_CNT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e           state_q;
    logic [1:0]       cnt_q;
    logic [31:0]      pend_data_q;
    logic             pend_err_q;
    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept;
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rsp_data;
    logic             rsp_err;

    assign gnt_o  = req_i & (state_q == StIdle);
    assign accept = gnt_o;  // gnt_o already implies req_i

    assign hit = ({1'b0, addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, addr_i} < END_ADDR);
    // BASE_ADDR is word aligned, so the low index bits of the difference are exact.
    assign idx = addr_i[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];

    always_comb begin
        rsp_data = 32'h0;
        rsp_err  = ~hit;
        if (hit && !we_i) begin
            rsp_data = mem[idx];
        end
    end

    // Array has no reset so contents survive rst; writes are blocked while rst is high.
    always_ff @(posedge clk) begin
        if (accept && hit && we_i && !rst) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 2'd0;
            pend_data_q <= 32'h0;
            pend_err_q  <= 1'b0;
            rvalid_o    <= 1'b0;
            rdata_o     <= 32'h0;
            err_o       <= 1'b0;
        end else begin
            rvalid_o <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (LATENCY <= 1) begin
                            // Accept edge is also the response edge; stay idle.
                            rvalid_o <= 1'b1;
                            rdata_o  <= rsp_data;
                            err_o    <= rsp_err;
                        end else begin
                            state_q     <= StBusy;
                            cnt_q       <= 2'd0;
                            pend_data_q <= rsp_data;
                            pend_err_q  <= rsp_err;
                        end
                    end
                end
                StBusy: begin
                    if (cnt_q == LAST_CNT) begin
                        state_q  <= StIdle;
                        rvalid_o <= 1'b1;
                        rdata_o  <= pend_data_q;
                        err_o    <= pend_err_q;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rsp_sram.sv
// Bench for mem_rsp_sram: three instances with LATENCY 1, 3 and 2 share a clock.
// A reference model predicts each response; predictions are queued when a request is
// driven and popped when the matching rvalid appears.
module tb_mem_rsp_sram;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int unsigned DEPTH = 4096;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst    [3];
    logic        req    [3];
    logic        we     [3];
    logic [31:0] addr   [3];
    logic [3:0]  be     [3];
    logic [31:0] wdata  [3];
    logic        gnt    [3];
    logic        rvalid [3];
    logic [31:0] rdata  [3];
    logic        err    [3];

    int          lat     [3] = '{1, 3, 2};
    int          acc     [3] = '{0, 0, 0};
    int          rv      [3] = '{0, 0, 0};
    int          dropped [3] = '{0, 0, 0};
    int          total = 0;
    int          bad   = 0;
    rsp_t        exp_q [$];
    logic [31:0] model [int];

    always #5 clk = ~clk;

    mem_rsp_sram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst[0]), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .be_i(be[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]), .err_o(err[0])
    );
    mem_rsp_sram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst[1]), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .be_i(be[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]), .err_o(err[1])
    );
    mem_rsp_sram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst[2]), .req_i(req[2]), .we_i(we[2]), .addr_i(addr[2]),
        .be_i(be[2]), .wdata_i(wdata[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
        .rdata_o(rdata[2]), .err_o(err[2])
    );

    // rvalid is a one-cycle pulse, so each pulse is seen at exactly one falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rvalid[d] === 1'b1) rv[d]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Issue one request on instance d starting at a falling edge; returns at the falling
    // edge of the rvalid cycle. With hold set, req stays high through BUSY.
    task automatic do_req(input int d, input bit w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] wd, input bit hold);
        rsp_t        e;
        rsp_t        got;
        bit          hit;
        int          key;
        int          n;
        logic [31:0] word;
        hit   = (a >= BASE) && ({1'b0, a} < ({1'b0, BASE} + 33'(4 * DEPTH)));
        key   = d * int'(DEPTH) + int'((a - BASE) >> 2);
        e.err = !hit;
        e.rdata = 32'h0;
        if (hit && !w) e.rdata = model.exists(key) ? model[key] : 32'h0;
        if (hit && w) begin
            word = model.exists(key) ? model[key] : 32'h0;
            for (int k = 0; k < 4; k++) if (b[k]) word[8*k +: 8] = wd[8*k +: 8];
            model[key] = word;
        end
        exp_q.push_back(e);

        req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
        #1;
        check("gnt_same_cycle", 32'(gnt[d]), 32'd1);
        @(posedge clk);
        acc[d]++;
        @(negedge clk);
        if (!hold) begin
            // Inputs are don't-care after the accept edge.
            req[d] = 1'b0; we[d] = ~w; addr[d] = $urandom; be[d] = 4'($urandom);
            wdata[d] = $urandom;
        end
        n = 1;
        while (rvalid[d] !== 1'b1 && n < 10) begin
            if (hold) check("gnt_busy", 32'(gnt[d]), 32'd0);
            @(negedge clk);
            n++;
        end
        got = exp_q.pop_front();
        if (rvalid[d] !== 1'b1) begin
            check("rvalid_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(n), 32'(lat[d]));
            check("rdata", rdata[d], got.rdata);
            check("err", 32'(err[d]), 32'(got.err));
            if (hold) begin
                check("gnt_rvalid_cycle", 32'(gnt[d]), 32'd1);
                req[d] = 1'b0;
            end
        end
    endtask

    initial begin
        int          wi;
        logic [31:0] a;
        bit          w;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'h0;
            be[d] = 4'h0; wdata[d] = 32'h0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_rvalid", 32'(rvalid[d]), 32'd0);
            check("rst_rdata", rdata[d], 32'h0);
            check("rst_err", 32'(err[d]), 32'd0);
            check("rst_gnt_noreq", 32'(gnt[d]), 32'd0);
        end

        // Full store then load, LATENCY=1
        do_req(0, 1'b1, BASE, 4'hF, 32'hDEAD_BEEF, 1'b0);
        do_req(0, 1'b0, BASE, 4'h0, 32'h0, 1'b0);
        check("t1_const", rdata[0], 32'hDEAD_BEEF);

        // Single-lane store through an unaligned address
        do_req(0, 1'b1, BASE + 32'd2, 4'b0100, 32'h00AB_0000, 1'b0);
        do_req(0, 1'b0, BASE, 4'h0, 32'h0, 1'b0);
        check("t2_const", rdata[0], 32'hDEAB_BEEF);
        do_req(0, 1'b1, BASE, 4'h0, 32'hFFFF_FFFF, 1'b0);
        do_req(0, 1'b0, BASE, 4'h0, 32'h0, 1'b0);

        // Out-of-range boundaries and last word in range
        do_req(0, 1'b0, BASE + 4 * DEPTH, 4'h0, 32'h0, 1'b0);
        check("t4_miss_err", 32'(err[0]), 32'd1);
        do_req(0, 1'b1, BASE - 32'd4, 4'hF, 32'h1234_5678, 1'b0);
        do_req(0, 1'b0, BASE, 4'h0, 32'h0, 1'b0);
        do_req(0, 1'b1, BASE + 4 * DEPTH - 4, 4'hF, 32'hCAFE_F00D, 1'b0);
        do_req(0, 1'b0, BASE + 4 * DEPTH - 4, 4'h0, 32'h0, 1'b0);

        // LATENCY=3 with req held high through BUSY
        do_req(1, 1'b1, BASE, 4'hF, 32'h1122_3344, 1'b1);
        do_req(1, 1'b0, BASE, 4'h0, 32'h0, 1'b1);
        do_req(1, 1'b0, BASE + 32'hFFFF, 4'h0, 32'h0, 1'b0);

        // Reset mid-load on LATENCY=2 drops the response but keeps the array
        do_req(2, 1'b1, BASE + 32'd8, 4'hF, 32'h5A5A_A5A5, 1'b0);
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = BASE + 32'd8;
        #1;
        check("t5_gnt", 32'(gnt[2]), 32'd1);
        @(posedge clk);
        acc[2]++;
        dropped[2]++;
        @(negedge clk);
        req[2] = 1'b0;
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t5_no_rvalid", 32'(rvalid[2]), 32'd0);
            @(negedge clk);
        end
        check("t5_rdata_rst", rdata[2], 32'h0);
        do_req(2, 1'b0, BASE + 32'd8, 4'h0, 32'h0, 1'b0);

        // Random traffic on LATENCY=1, back to back, over eight pre-written words
        for (int i = 0; i < 8; i++) do_req(0, 1'b1, BASE + 32'h40 + 32'(4 * i), 4'hF, $urandom, 1'b0);
        for (int i = 0; i < 100; i++) begin
            wi = $urandom_range(0, 7);
            a  = BASE + 32'h40 + 32'(4 * wi) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)
                a = ($urandom_range(0, 1) == 1) ? BASE - 32'(4 * $urandom_range(1, 4))
                                                : BASE + 4 * DEPTH + 32'($urandom_range(0, 64));
            w = 1'($urandom_range(0, 1));
            do_req(0, w, a, 4'($urandom), $urandom, 1'b0);
        end

        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) check("one_rvalid_per_accept", 32'(rv[d]), 32'(acc[d] - dropped[d]));
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
